forward_stall_unit: RTL and testbench
=====================================

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

Interface
REQ-001 The block SHALL have parameter NBits, default 32, giving the operand data width.
REQ-002 The block SHALL have parameter RAddr, default 5, giving the register address width.
REQ-003 The block SHALL have parameter LOAD_STALL, default 1, range 1..3, giving load-use stall cycles.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-low reset.
REQ-007 Id_Valid_i  in  1  valid instruction in ID.
REQ-008 Id_Rs1_i, Id_Rs2_i, Id_Rd_i  in  RAddr  ID source and destination registers.
REQ-009 Id_RegWrite_i, Id_MemRead_i  in  1  ID writes the register file / ID is a load.
REQ-010 Flush_i  in  1  kills the ID instruction and the EX slot.
REQ-011 Rs1_Data_i, Rs2_Data_i  in  NBits  register-file operands of the EX instruction.
REQ-012 Mem_Result_i, Wb_Result_i  in  NBits  MEM-stage result / WB-stage write data.
REQ-013 Op1_o, Op2_o  out  NBits  resolved EX operands.
REQ-014 Fwd1_Sel_o, Fwd2_Sel_o  out  2  operand source: 00 register file, 01 WB, 10 MEM.
REQ-015 Stall_o  out  1  hold IF/ID and insert a bubble into EX.

Function
REQ-016 The block SHALL hold EX, MEM and WB tracking slots, each with {valid, rd, regwrite, memread}; the EX slot SHALL also hold {rs1, rs2}.
REQ-017 Each clock edge SHALL shift WB<=MEM and MEM<=EX.
REQ-018 EX SHALL load the ID fields when Id_Valid_i=1, Stall_o=0 and Flush_i=0; otherwise EX SHALL load a bubble (valid=0).
REQ-019 A slot SHALL match an operand register r only when valid=1, regwrite=1, rd!=0 and rd==r.
REQ-020 FwdN_Sel_o SHALL be 10 on a MEM match, else 01 on a WB match, else 00.
REQ-021 If MEM and WB both match, MEM SHALL have priority.
REQ-022 An invalid EX slot SHALL force 00.
REQ-023 OpN_o SHALL be a combinational mux selected by FwdN_Sel_o, with zero-cycle latency.
REQ-024 The load-use hazard SHALL be: Id_Valid_i & EX.valid & EX.memread & EX.rd!=0 & (EX.rd==Id_Rs1_i | EX.rd==Id_Rs2_i).
REQ-025 The stall FSM SHALL have states IDLE and STALL, with a 2-bit down-counter.
REQ-026 In IDLE, a hazard SHALL assert Stall_o combinationally in the same cycle and load the counter with LOAD_STALL-1; the FSM SHALL move to STALL if LOAD_STALL>1.
REQ-027 In STALL, Stall_o SHALL be 1 and the counter SHALL decrement each cycle; counter==0 SHALL return the FSM to IDLE.
REQ-028 Stall_o SHALL therefore be high for exactly LOAD_STALL consecutive cycles per hazard.
REQ-029 A new hazard SHALL be evaluated only after the FSM returns to IDLE.
REQ-030 Flush_i SHALL override stall: Stall_o=0 in that cycle, the FSM goes to IDLE, the counter clears and EX takes a bubble.
REQ-031 Once a producer has retired past WB, the operand SHALL be taken from the register file (write-first register file).
REQ-032 Register x0 SHALL never forward and never stall.

Reset
REQ-033 On reset low, all slot valid bits SHALL clear, the FSM SHALL go to IDLE, the counter SHALL be 0 and the statistics counters SHALL be 0, immediately and independent of clk.
REQ-034 While reset is low, outputs SHALL be Fwd1_Sel_o=Fwd2_Sel_o=00, Stall_o=0, Op1_o=Rs1_Data_i and Op2_o=Rs2_Data_i.
REQ-035 Reset asserted mid-stall SHALL abort the stall.

Configuration
REQ-036 With macro HAZARD_STATS_EN defined, the block SHALL add outputs Fwd_Count_o[15:0] and Stall_Count_o[15:0], both saturating at 0xFFFF.
REQ-037 Fwd_Count_o SHALL increment by 1 per cycle in which either FwdN_Sel_o!=00.
REQ-038 Stall_Count_o SHALL increment by 1 per cycle in which Stall_o=1.
REQ-039 Without HAZARD_STATS_EN, these ports and registers SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-040 MEM slot writes x5 and EX rs1=x5, Mem_Result_i=0xDEADBEEF -> Fwd1_Sel_o=10, Op1_o=0xDEADBEEF.
REQ-041 MEM and WB both write x7 and EX rs2=x7, Mem=0x11, Wb=0x22 -> Fwd2_Sel_o=10, Op2_o=0x11.
REQ-042 LOAD_STALL=2, load writing x3 in EX, ID reads x3 -> Stall_o=1 for 2 cycles, EX bubble, then Fwd1_Sel_o=01 or 00 as specified, Op1_o=load data.
REQ-043 Producer writes x0, EX reads x0, plus load to x0 -> Fwd_Sel=00, Stall_o=0.
REQ-044 Flush_i=1 in the first cycle of a LOAD_STALL=3 stall -> Stall_o=0 that cycle, FSM in IDLE next cycle, EX invalid.
REQ-045 reset pulsed low mid-stall with HAZARD_STATS_EN -> Stall_o=0 and both counters 0 immediately; the counters saturate at 0xFFFF after 65535+ stall cycles.

Source files
------------

// File: rtl/forward_stall_unit.sv
// forward_stall_unit: EX-stage operand forwarding from MEM/WB and load-use stall control.
// Optional build macro HAZARD_STATS_EN adds saturating forward/stall event counters.
module forward_stall_unit #(
    parameter int NBits      = 32,
    parameter int RAddr      = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Id_Valid_i,
    input  logic [RAddr-1:0] Id_Rs1_i,
    input  logic [RAddr-1:0] Id_Rs2_i,
    input  logic [RAddr-1:0] Id_Rd_i,
    input  logic             Id_RegWrite_i,
    input  logic             Id_MemRead_i,
    input  logic             Flush_i,
    input  logic [NBits-1:0] Rs1_Data_i,
    input  logic [NBits-1:0] Rs2_Data_i,
    input  logic [NBits-1:0] Mem_Result_i,
    input  logic [NBits-1:0] Wb_Result_i,
    output logic [NBits-1:0] Op1_o,
    output logic [NBits-1:0] Op2_o,
    output logic [1:0]       Fwd1_Sel_o,
    output logic [1:0]       Fwd2_Sel_o,
    output logic             Stall_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]      Fwd_Count_o,
    output logic [15:0]      Stall_Count_o
`endif
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] CNT_INIT = 2'(LOAD_STALL - 1);

    typedef struct packed {
        logic             valid;
        logic [RAddr-1:0] rd;
        logic             regwrite;
        logic             memread;
    } slot_t;

    // state  | meaning
    // IDLE   | no stall in progress; load-use hazards are evaluated here
    // STALL  | holding IF/ID for the remaining load-use cycles
    typedef enum logic {
        S_IDLE,
        S_STALL
    } state_t;

    slot_t            ex_slot;
    slot_t            mem_slot;
    slot_t            wb_slot;
    logic [RAddr-1:0] ex_rs1;
    logic [RAddr-1:0] ex_rs2;
    state_t           state;
    logic [1:0]       stall_cnt;
    logic             hazard;
    logic             ex_load;
    logic             wb_memread_unused;

    function automatic logic slot_match(input slot_t s, input logic [RAddr-1:0] r);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == r);
    endfunction

    function automatic logic [1:0] fwd_select(input logic [RAddr-1:0] r);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_slot.valid) begin
            if (slot_match(mem_slot, r)) begin
                sel = SEL_MEM;
            end else if (slot_match(wb_slot, r)) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    // WB memread is tracked for slot symmetry but nothing downstream consumes it.
    assign wb_memread_unused = wb_slot.memread;

    assign hazard = Id_Valid_i && ex_slot.valid && ex_slot.memread &&
                    (ex_slot.rd != '0) &&
                    ((ex_slot.rd == Id_Rs1_i) || (ex_slot.rd == Id_Rs2_i));

    assign Stall_o = !Flush_i && ((state == S_STALL) || hazard);
    assign ex_load = Id_Valid_i && !Stall_o && !Flush_i;

    always_comb begin
        Fwd1_Sel_o = fwd_select(ex_rs1);
        Fwd2_Sel_o = fwd_select(ex_rs2);
    end

    always_comb begin
        Op1_o = Rs1_Data_i;
        case (Fwd1_Sel_o)
            SEL_MEM: Op1_o = Mem_Result_i;
            SEL_WB:  Op1_o = Wb_Result_i;
            default: Op1_o = Rs1_Data_i;
        endcase
    end

    always_comb begin
        Op2_o = Rs2_Data_i;
        case (Fwd2_Sel_o)
            SEL_MEM: Op2_o = Mem_Result_i;
            SEL_WB:  Op2_o = Wb_Result_i;
            default: Op2_o = Rs2_Data_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (ex_load) begin
                ex_slot.valid    <= 1'b1;
                ex_slot.rd       <= Id_Rd_i;
                ex_slot.regwrite <= Id_RegWrite_i;
                ex_slot.memread  <= Id_MemRead_i;
                ex_rs1           <= Id_Rs1_i;
                ex_rs2           <= Id_Rs2_i;
            end else begin
                ex_slot <= '0;
                ex_rs1  <= '0;
                ex_rs2  <= '0;
            end
        end
    end

    // The counter holds the stall cycles still owed after the current one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            stall_cnt <= 2'd0;
        end else if (Flush_i) begin
            state     <= S_IDLE;
            stall_cnt <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hazard) begin
                        stall_cnt <= CNT_INIT;
                        if (LOAD_STALL > 1) begin
                            state <= S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    stall_cnt <= stall_cnt - 2'd1;
                    if (stall_cnt <= 2'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    stall_cnt <= 2'd0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] fwd_count;
    logic [15:0] stall_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fwd_count   <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (((Fwd1_Sel_o != SEL_RF) || (Fwd2_Sel_o != SEL_RF)) && (fwd_count != 16'hFFFF)) begin
                fwd_count <= fwd_count + 16'd1;
            end
            if (Stall_o && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign Fwd_Count_o   = fwd_count;
    assign Stall_Count_o = stall_count;
`endif

endmodule

// File: tb/tb_forward_stall_unit.sv
// Bench for forward_stall_unit: two instances (LOAD_STALL=2 and 3) share stimulus and are
// checked every cycle against a pipeline model; HAZARD_STATS_EN also checks the counters.
`timescale 1ns/1ps
module tb_forward_stall_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_rw = 1'b0, id_mr = 1'b0, flush = 1'b0;
    logic [31:0] rs1_data = 32'h1000_0001, rs2_data = 32'h2000_0002;
    logic [31:0] mem_res = 32'h3000_0003, wb_res = 32'h4000_0004;

    logic [31:0] op1 [2];
    logic [31:0] op2 [2];
    logic [1:0]  sel1 [2];
    logic [1:0]  sel2 [2];
    logic        stall [2];
`ifdef HAZARD_STATS_EN
    logic [15:0] fcnt [2];
    logic [15:0] scnt [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_stall_unit #(.NBits(32), .RAddr(5), .LOAD_STALL(2)) u0 (
        .clk(clk), .reset(reset), .Id_Valid_i(id_valid), .Id_Rs1_i(id_rs1), .Id_Rs2_i(id_rs2),
        .Id_Rd_i(id_rd), .Id_RegWrite_i(id_rw), .Id_MemRead_i(id_mr), .Flush_i(flush),
        .Rs1_Data_i(rs1_data), .Rs2_Data_i(rs2_data), .Mem_Result_i(mem_res), .Wb_Result_i(wb_res),
        .Op1_o(op1[0]), .Op2_o(op2[0]), .Fwd1_Sel_o(sel1[0]), .Fwd2_Sel_o(sel2[0]), .Stall_o(stall[0])
`ifdef HAZARD_STATS_EN
        , .Fwd_Count_o(fcnt[0]), .Stall_Count_o(scnt[0])
`endif
    );

    forward_stall_unit #(.NBits(32), .RAddr(5), .LOAD_STALL(3)) u1 (
        .clk(clk), .reset(reset), .Id_Valid_i(id_valid), .Id_Rs1_i(id_rs1), .Id_Rs2_i(id_rs2),
        .Id_Rd_i(id_rd), .Id_RegWrite_i(id_rw), .Id_MemRead_i(id_mr), .Flush_i(flush),
        .Rs1_Data_i(rs1_data), .Rs2_Data_i(rs2_data), .Mem_Result_i(mem_res), .Wb_Result_i(wb_res),
        .Op1_o(op1[1]), .Op2_o(op2[1]), .Fwd1_Sel_o(sel1[1]), .Fwd2_Sel_o(sel2[1]), .Stall_o(stall[1])
`ifdef HAZARD_STATS_EN
        , .Fwd_Count_o(fcnt[1]), .Stall_Count_o(scnt[1])
`endif
    );

    // ---------------- model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ins_t;

    ins_t pipe [2][3];          // [instance][0=EX,1=MEM,2=WB]
    int   stall_start [2];      // cycle at which the current stall began
    int   lat [2];
    int   cyc = 0;
    int   m_fcnt [2];
    int   m_scnt [2];

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    function automatic bit hit(input ins_t s, input logic [4:0] r);
        return s.v && s.rw && (s.rd != 5'd0) && (s.rd == r);
    endfunction

    function automatic logic [1:0] esel(input int i, input logic [4:0] r);
        if (!pipe[i][0].v) return 2'b00;
        if (hit(pipe[i][1], r)) return 2'b10;
        if (hit(pipe[i][2], r)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] eop(input logic [1:0] s, input logic [31:0] rf);
        if (s == 2'b10) return mem_res;
        if (s == 2'b01) return wb_res;
        return rf;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) pipe[i][j] = '0;
            stall_start[i] = -1000;
            m_fcnt[i] = 0;
            m_scnt[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) model_clear();
        for (int i = 0; i < 2; i++) begin
            logic [1:0] e1, e2;
            bit         hz, es;
            ins_t       nx;
            e1 = esel(i, pipe[i][0].rs1);
            e2 = esel(i, pipe[i][0].rs2);
            hz = reset && id_valid && pipe[i][0].v && pipe[i][0].mr && (pipe[i][0].rd != 5'd0) &&
                 ((pipe[i][0].rd == id_rs1) || (pipe[i][0].rd == id_rs2));
            if (!reset || flush) begin
                es = 1'b0;
                stall_start[i] = -1000;
            end else if (cyc - stall_start[i] < lat[i]) begin
                es = 1'b1;
            end else if (hz) begin
                es = 1'b1;
                stall_start[i] = cyc;
            end else begin
                es = 1'b0;
            end
            chk("sel1", i, 32'(sel1[i]), 32'(e1));
            chk("sel2", i, 32'(sel2[i]), 32'(e2));
            chk("op1", i, op1[i], eop(e1, rs1_data));
            chk("op2", i, op2[i], eop(e2, rs2_data));
            chk("stall", i, 32'(stall[i]), 32'(es));
`ifdef HAZARD_STATS_EN
            chk("fwd_count", i, 32'(fcnt[i]), 32'(m_fcnt[i]));
            chk("stall_count", i, 32'(scnt[i]), 32'(m_scnt[i]));
`endif
            if (reset) begin
                if ((e1 != 2'b00 || e2 != 2'b00) && m_fcnt[i] < 65535) m_fcnt[i]++;
                if (es && m_scnt[i] < 65535) m_scnt[i]++;
                nx = (id_valid && !es && !flush) ? {1'b1, id_rd, id_rw, id_mr, id_rs1, id_rs2} : '0;
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = pipe[i][0];
                pipe[i][0] = nx;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit rw, input bit mr);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_rw = rw; id_mr = mr;
    endtask

    task automatic nop();
        id_set(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic chk_stall(input string nm, input bit e0, input bit e1);
        chk(nm, 0, 32'(stall[0]), 32'(e0));
        chk(nm, 1, 32'(stall[1]), 32'(e1));
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 3;
        model_clear();

        // reset state
        #1 reset = 1'b0;
        #1;
        chk_stall("rst_stall", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("rst_sel1", i, 32'(sel1[i]), 32'd0);
            chk("rst_op1", i, op1[i], 32'h1000_0001);
            chk("rst_op2", i, op2[i], 32'h2000_0002);
        end
        tick(); reset = 1'b1;

        // MEM forward of x5
        tick(); id_set(1, 5, 1, 2, 1, 0);
        tick(); id_set(1, 8, 5, 6, 1, 0);
        tick(); nop(); mem_res = 32'hDEADBEEF; #1;
        for (int i = 0; i < 2; i++) begin
            chk("mem_fwd_sel1", i, 32'(sel1[i]), 32'd2);
            chk("mem_fwd_op1", i, op1[i], 32'hDEADBEEF);
        end

        // MEM beats WB, then WB only, then retired -> register file
        tick(); id_set(1, 7, 0, 0, 1, 0);
        tick(); id_set(1, 7, 0, 0, 1, 0);
        tick(); id_set(1, 9, 1, 7, 0, 0);
        tick(); id_set(1, 10, 2, 7, 0, 0); mem_res = 32'h11; wb_res = 32'h22; #1;
        for (int i = 0; i < 2; i++) begin
            chk("prio_sel2", i, 32'(sel2[i]), 32'd2);
            chk("prio_op2", i, op2[i], 32'h11);
        end
        tick(); id_set(1, 11, 3, 7, 0, 0); #1;
        for (int i = 0; i < 2; i++) begin
            chk("wb_sel2", i, 32'(sel2[i]), 32'd1);
            chk("wb_op2", i, op2[i], 32'h22);
        end
        tick(); nop(); rs2_data = 32'h2222_0000; #1;
        for (int i = 0; i < 2; i++) begin
            chk("retired_sel2", i, 32'(sel2[i]), 32'd0);
            chk("retired_op2", i, op2[i], 32'h2222_0000);
        end

        // load-use on x3: u0 stalls 2 cycles, u1 stalls 3
        tick(); id_set(1, 3, 1, 2, 1, 1);
        tick(); id_set(1, 12, 3, 0, 1, 0); rs1_data = 32'hABCD_0003; #1;
        chk_stall("lu_c1", 1'b1, 1'b1);
        tick(); #1; chk_stall("lu_c2", 1'b1, 1'b1);
        tick(); #1; chk_stall("lu_c3", 1'b0, 1'b1);
        tick(); #1; chk_stall("lu_c4", 1'b0, 1'b0);
        chk("lu_sel1", 0, 32'(sel1[0]), 32'd0);
        chk("lu_op1", 0, op1[0], 32'hABCD_0003);
        tick(); nop(); #1;
        chk("lu_sel1", 1, 32'(sel1[1]), 32'd0);
        chk("lu_op1", 1, op1[1], 32'hABCD_0003);

        // x0 never forwards or stalls
        tick(); id_set(1, 0, 1, 2, 1, 0);
        tick(); id_set(1, 0, 0, 0, 1, 1);
        tick(); id_set(1, 13, 0, 0, 1, 0); #1;
        chk_stall("x0_stall", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) chk("x0_sel1", i, 32'(sel1[i]), 32'd0);
        tick(); nop(); #1;
        chk_stall("x0_stall2", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) chk("x0_sel2", i, 32'(sel2[i]), 32'd0);

        // flush in the first stall cycle
        tick(); id_set(1, 4, 1, 2, 1, 1);
        tick(); id_set(1, 14, 1, 4, 1, 0); flush = 1'b1; #1;
        chk_stall("flush_c1", 1'b0, 1'b0);
        tick(); flush = 1'b0; #1;
        chk_stall("flush_c2", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) chk("flush_ex_bubble", i, 32'(sel2[i]), 32'd0);
        tick(); nop(); #1;
        for (int i = 0; i < 2; i++) begin
            chk("after_flush_sel2", i, 32'(sel2[i]), 32'd1);
            chk("after_flush_op2", i, op2[i], 32'h22);
        end

        // flush in the second stall cycle
        tick(); id_set(1, 6, 1, 2, 1, 1);
        tick(); id_set(1, 15, 6, 1, 1, 0);
        tick(); flush = 1'b1; #1;
        chk_stall("flush_mid", 1'b0, 1'b0);
        tick(); flush = 1'b0;
        tick(); nop();

        // reset pulse in the middle of a stall
        tick(); id_set(1, 9, 1, 2, 1, 1);
        tick(); id_set(1, 16, 9, 9, 1, 0); #1;
        chk_stall("pre_rst", 1'b1, 1'b1);
        tick(); #1; reset = 1'b0; #1;
        chk_stall("mid_rst_stall", 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk("mid_rst_sel2", i, 32'(sel2[i]), 32'd0);
            chk("mid_rst_op1", i, op1[i], 32'hABCD_0003);
`ifdef HAZARD_STATS_EN
            chk("mid_rst_fcnt", i, 32'(fcnt[i]), 32'd0);
            chk("mid_rst_scnt", i, 32'(scnt[i]), 32'd0);
`endif
        end
        tick(); reset = 1'b1;

        // mixed traffic on a small register set, checked by the model
        for (int n = 0; n < 60; n++) begin
            tick();
            id_set(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            flush    = ($urandom_range(0, 7) == 0);
            rs1_data = $urandom; rs2_data = $urandom; mem_res = $urandom; wb_res = $urandom;
        end
        tick(); nop(); flush = 1'b0;

`ifdef HAZARD_STATS_EN
        // back-to-back dependent loads drive the stall counter into saturation
        tick(); id_set(1, 3, 3, 0, 1, 1);
        repeat (87500) tick();
        #1;
        chk("stall_cnt_sat", 1, 32'(scnt[1]), 32'h0000_FFFF);
        tick(); nop();
        tick(); #1; reset = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            chk("sat_rst_fcnt", i, 32'(fcnt[i]), 32'd0);
            chk("sat_rst_scnt", i, 32'(scnt[i]), 32'd0);
        end
        tick(); reset = 1'b1;
`endif

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
